// File: rtl/jtkcpu_intseq_pkg.sv
// Shared definitions for the KONAMI-1 interrupt-entry/RTI sequencer:
// CC bit positions, default vectors, sequencer states and interrupt sources.
package jtkcpu_intseq_pkg;

    localparam int unsigned CC_E = 7;
    localparam int unsigned CC_F = 6;
    localparam int unsigned CC_I = 4;

    localparam logic [15:0] VEC_NMI_DEF  = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF  = 16'hFFF8;
    localparam logic [15:0] VEC_FIRQ_DEF = 16'hFFF6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PSH,
        ST_PWAIT,
        ST_VHI,
        ST_VLO,
        ST_JMP,
        ST_RCC,
        ST_RCW,
        ST_ROT,
        ST_ROW
    } state_t;

    typedef enum logic [1:0] {
        SRC_NMI,
        SRC_FIRQ,
        SRC_IRQ
    } src_t;

    function automatic logic [7:0] cc_bit(input int unsigned idx);
        logic [7:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/jtkcpu_intseq_intsync.sv
// NMI falling-edge detector and pending latch. With JTKCPU_NMI_ARM_EN defined,
// NMI stays disarmed until the first system stack pointer write (s_wr).
module jtkcpu_intsync (
    input  logic rst,
    input  logic clk,
    input  logic cen,
    input  logic nmi_n,
`ifdef JTKCPU_NMI_ARM_EN
    input  logic s_wr,
`endif
    input  logic clr,
    output logic nmi_lat
);

    logic nmi_q;
    logic armed;

`ifdef JTKCPU_NMI_ARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (cen && s_wr) begin
            armed <= 1'b1;
        end
    end
`else
    assign armed = 1'b1;
`endif

    // A fresh edge wins over a simultaneous clear so it is never dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_q   <= 1'b1;
            nmi_lat <= 1'b0;
        end else if (cen) begin
            nmi_q <= nmi_n;
            if (armed && nmi_q && !nmi_n) begin
                nmi_lat <= 1'b1;
            end else if (clr) begin
                nmi_lat <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtkcpu_intseq.sv
// KONAMI-1 interrupt-entry and RTI sequencer: arbitration, CC E/F/I updates,
// push/pull launch, vector fetch and PC load. Optional macro: JTKCPU_NMI_ARM_EN.
module jtkcpu_intseq
    import jtkcpu_intseq_pkg::*;
#(
    parameter logic [15:0] VEC_NMI  = VEC_NMI_DEF,
    parameter logic [15:0] VEC_IRQ  = VEC_IRQ_DEF,
    parameter logic [15:0] VEC_FIRQ = VEC_FIRQ_DEF
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        firq_n,
    input  logic [7:0]  cc,
    input  logic        boundary,
    input  logic        rti_req,
    input  logic        pp_busy,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_din,
`ifdef JTKCPU_NMI_ARM_EN
    input  logic        s_wr,
`endif
    output logic        psh_go,
    output logic        pul_go,
    output logic        psh_all,
    output logic        psh_cc,
    output logic        rti_cc,
    output logic        rti_other,
    output logic [7:0]  cc_set,
    output logic [7:0]  cc_clr,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        pc_ld,
    output logic [15:0] pc_din,
    output logic        busy,
    output logic        int_ack
);

    state_t      state;
    src_t        src;
    logic [15:0] vec;
    logic [7:0]  hi;
    logic        nmi_lat;
    logic        nmi_clr;
    logic        firq_ok;
    logic        irq_ok;
    // only the F and I masks matter to arbitration
    logic        unused_cc;

    assign unused_cc = ^{cc[7], cc[5], cc[3:0]};

    always_comb begin
        firq_ok = !firq_n && !cc[CC_F];
        irq_ok  = !irq_n  && !cc[CC_I];
        nmi_clr = cen && (state == ST_IDLE) && boundary && nmi_lat;
    end

    jtkcpu_intsync u_sync (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .nmi_n   (nmi_n),
`ifdef JTKCPU_NMI_ARM_EN
        .s_wr    (s_wr),
`endif
        .clr     (nmi_clr),
        .nmi_lat (nmi_lat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            src       <= SRC_NMI;
            vec       <= '0;
            hi        <= '0;
            psh_go    <= 1'b0;
            pul_go    <= 1'b0;
            psh_all   <= 1'b0;
            psh_cc    <= 1'b0;
            rti_cc    <= 1'b0;
            rti_other <= 1'b0;
            cc_set    <= '0;
            cc_clr    <= '0;
            vec_rd    <= 1'b0;
            vec_addr  <= '0;
            pc_ld     <= 1'b0;
            pc_din    <= '0;
            busy      <= 1'b0;
            int_ack   <= 1'b0;
        end else if (cen) begin
            psh_go    <= 1'b0;
            pul_go    <= 1'b0;
            psh_all   <= 1'b0;
            psh_cc    <= 1'b0;
            rti_cc    <= 1'b0;
            rti_other <= 1'b0;
            cc_set    <= '0;
            cc_clr    <= '0;
            pc_ld     <= 1'b0;
            int_ack   <= 1'b0;
            case (state)
                ST_IDLE: if (boundary) begin
                    if (nmi_lat || firq_ok || irq_ok) begin
                        state  <= ST_PSH;
                        busy   <= 1'b1;
                        psh_go <= 1'b1;
                        if (nmi_lat) begin
                            src <= SRC_NMI;
                            vec <= VEC_NMI;
                        end else if (firq_ok) begin
                            src <= SRC_FIRQ;
                            vec <= VEC_FIRQ;
                        end else begin
                            src <= SRC_IRQ;
                            vec <= VEC_IRQ;
                        end
                        // FIRQ stacks only PC+CC, so E must read back as clear
                        if (!nmi_lat && firq_ok) begin
                            cc_clr <= cc_bit(CC_E);
                            psh_cc <= 1'b1;
                        end else begin
                            cc_set  <= cc_bit(CC_E);
                            psh_all <= 1'b1;
                        end
                    end else if (rti_req) begin
                        state  <= ST_RCC;
                        busy   <= 1'b1;
                        pul_go <= 1'b1;
                        rti_cc <= 1'b1;
                    end
                end
                ST_PSH: state <= ST_PWAIT;
                ST_PWAIT: if (!pp_busy) begin
                    state    <= ST_VHI;
                    cc_set   <= (src == SRC_IRQ) ? cc_bit(CC_I) : (cc_bit(CC_F) | cc_bit(CC_I));
                    vec_rd   <= 1'b1;
                    vec_addr <= vec;
                end
                ST_VHI: if (mem_rdy) begin
                    state    <= ST_VLO;
                    hi       <= mem_din;
                    vec_addr <= vec + 16'd1;
                end
                ST_VLO: if (mem_rdy) begin
                    state   <= ST_JMP;
                    vec_rd  <= 1'b0;
                    pc_din  <= {hi, mem_din};
                    pc_ld   <= 1'b1;
                    int_ack <= 1'b1;
                end
                ST_JMP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_RCC: state <= ST_RCW;
                ST_RCW: if (!pp_busy) begin
                    state     <= ST_ROT;
                    pul_go    <= 1'b1;
                    rti_other <= 1'b1;
                end
                ST_ROT: state <= ST_ROW;
                ST_ROW: if (!pp_busy) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_intseq.sv
// Directed-vector bench for jtkcpu_intseq: per-cycle table of inputs and expected
// outputs, plus hand-written reset and NMI-arming sequences.
module tb_jtkcpu_intseq;

    logic        rst, clk, cen;
    logic        nmi_n, irq_n, firq_n;
    logic [7:0]  cc;
    logic        boundary, rti_req, pp_busy, mem_rdy;
    logic [7:0]  mem_din;
`ifdef JTKCPU_NMI_ARM_EN
    logic        s_wr;
`endif
    logic        psh_go, pul_go, psh_all, psh_cc, rti_cc, rti_other;
    logic [7:0]  cc_set, cc_clr;
    logic        vec_rd, pc_ld, busy, int_ack;
    logic [15:0] vec_addr, pc_din;

    int nchk  = 0;
    int nfail = 0;

    jtkcpu_intseq dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .firq_n    (firq_n),
        .cc        (cc),
        .boundary  (boundary),
        .rti_req   (rti_req),
        .pp_busy   (pp_busy),
        .mem_rdy   (mem_rdy),
        .mem_din   (mem_din),
`ifdef JTKCPU_NMI_ARM_EN
        .s_wr      (s_wr),
`endif
        .psh_go    (psh_go),
        .pul_go    (pul_go),
        .psh_all   (psh_all),
        .psh_cc    (psh_cc),
        .rti_cc    (rti_cc),
        .rti_other (rti_other),
        .cc_set    (cc_set),
        .cc_clr    (cc_clr),
        .vec_rd    (vec_rd),
        .vec_addr  (vec_addr),
        .pc_ld     (pc_ld),
        .pc_din    (pc_din),
        .busy      (busy),
        .int_ack   (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl  = {cen, nmi_n, irq_n, firq_n, boundary, rti_req, pp_busy, mem_rdy}
    // flg  = {busy, psh_go, pul_go, psh_all, psh_cc, rti_cc, rti_other, vec_rd, pc_ld, int_ack}
    typedef struct {
        logic [7:0]  ctl;
        logic [7:0]  cc;
        logic [7:0]  din;
        logic [9:0]  flg;
        logic [7:0]  cset;
        logic [7:0]  cclr;
        logic [15:0] va;
        logic [15:0] pcd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [7:0] ctl, input logic [7:0] ccv, input logic [7:0] din,
                               input logic [9:0] flg, input logic [7:0] cset, input logic [7:0] cclr,
                               input logic [15:0] va, input logic [15:0] pcd);
        vec_t r;
        r.ctl = ctl; r.cc = ccv; r.din = din; r.flg = flg;
        r.cset = cset; r.cclr = cclr; r.va = va; r.pcd = pcd;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [7:0] ccv, input logic [7:0] din);
        {cen, nmi_n, irq_n, firq_n, boundary, rti_req, pp_busy, mem_rdy} = ctl;
        cc      = ccv;
        mem_din = din;
    endtask

    task automatic check(input string name, input logic [57:0] exp);
        logic [57:0] got;
        got = {busy, psh_go, pul_go, psh_all, psh_cc, rti_cc, rti_other, vec_rd, pc_ld, int_ack,
               cc_set, cc_clr, vec_addr, pc_din};
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(8'b1111_0000, 8'h00, 8'h00);
`ifdef JTKCPU_NMI_ARM_EN
        s_wr = 1'b0;
`endif
        step();
        check("reset_state", '0);
        rst = 1'b0;
        step();
`ifdef JTKCPU_NMI_ARM_EN
        s_wr = 1'b1;
        step();
        s_wr = 1'b0;
`endif

        // IRQ entry, cen freeze, request ignored while JMP ends the sequence
        tbl.push_back(v(8'b1101_1000, 8'h00, 8'h00, 10'b11_0100_0000, 8'h80, 8'h00, 16'h0000, 16'h0000));
        tbl.push_back(v(8'b0101_1000, 8'h00, 8'h00, 10'b11_0100_0000, 8'h80, 8'h00, 16'h0000, 16'h0000));
        tbl.push_back(v(8'b1101_0000, 8'h00, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'h0000, 16'h0000));
        tbl.push_back(v(8'b1111_0010, 8'h00, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'h0000, 16'h0000));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b10_0000_0100, 8'h10, 8'h00, 16'hFFF8, 16'h0000));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b10_0000_0100, 8'h00, 8'h00, 16'hFFF8, 16'h0000));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'h12, 10'b10_0000_0100, 8'h00, 8'h00, 16'hFFF9, 16'h0000));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'h34, 10'b10_0000_0011, 8'h00, 8'h00, 16'hFFF9, 16'h1234));
        tbl.push_back(v(8'b1101_1000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF9, 16'h1234));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF9, 16'h1234));
        // FIRQ beats IRQ
        tbl.push_back(v(8'b1100_1000, 8'h00, 8'h00, 10'b11_0010_0000, 8'h00, 8'h80, 16'hFFF9, 16'h1234));
        tbl.push_back(v(8'b1100_0010, 8'h00, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF9, 16'h1234));
        tbl.push_back(v(8'b1100_0000, 8'h00, 8'h00, 10'b10_0000_0100, 8'h50, 8'h00, 16'hFFF6, 16'h1234));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'hAB, 10'b10_0000_0100, 8'h00, 8'h00, 16'hFFF7, 16'h1234));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'hCD, 10'b10_0000_0011, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        // Masked interrupts, then RTI wins
        tbl.push_back(v(8'b1100_1000, 8'h50, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1100_1100, 8'h50, 8'h00, 10'b10_1001_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0010, 8'h50, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0010, 8'h50, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0000, 8'h50, 8'h00, 10'b10_1000_1000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0010, 8'h50, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0000, 8'h50, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        // NMI edge during IRQ entry is taken at the next boundary
        tbl.push_back(v(8'b1101_1000, 8'h00, 8'h00, 10'b11_0100_0000, 8'h80, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1011_0010, 8'h00, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF7, 16'hABCD));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b10_0000_0100, 8'h10, 8'h00, 16'hFFF8, 16'hABCD));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'h56, 10'b10_0000_0100, 8'h00, 8'h00, 16'hFFF9, 16'hABCD));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'h78, 10'b10_0000_0011, 8'h00, 8'h00, 16'hFFF9, 16'h5678));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFF9, 16'h5678));
        tbl.push_back(v(8'b1111_1000, 8'h00, 8'h00, 10'b11_0100_0000, 8'h80, 8'h00, 16'hFFF9, 16'h5678));
        tbl.push_back(v(8'b1111_0010, 8'h00, 8'h00, 10'b10_0000_0000, 8'h00, 8'h00, 16'hFFF9, 16'h5678));
        tbl.push_back(v(8'b1111_0000, 8'h00, 8'h00, 10'b10_0000_0100, 8'h50, 8'h00, 16'hFFFC, 16'h5678));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'h9A, 10'b10_0000_0100, 8'h00, 8'h00, 16'hFFFD, 16'h5678));
        tbl.push_back(v(8'b1111_0001, 8'h00, 8'hBC, 10'b10_0000_0011, 8'h00, 8'h00, 16'hFFFD, 16'h9ABC));
        tbl.push_back(v(8'b1111_1000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFFD, 16'h9ABC));
        tbl.push_back(v(8'b1111_1000, 8'h00, 8'h00, 10'b00_0000_0000, 8'h00, 8'h00, 16'hFFFD, 16'h9ABC));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ctl, tbl[i].cc, tbl[i].din);
            step();
            check($sformatf("vec%0d", i),
                  {tbl[i].flg, tbl[i].cset, tbl[i].cclr, tbl[i].va, tbl[i].pcd});
        end

        // Reset mid-PWAIT with an NMI pending
        drive(8'b1101_1000, 8'h00, 8'h00);
        step();
        drive(8'b1011_0010, 8'h00, 8'h00);
        step();
        drive(8'b1111_0010, 8'h00, 8'h00);
        #2 rst = 1'b1;
        #1 check("reset_mid_pwait", '0);
        step();
        rst = 1'b0;
        drive(8'b1111_1000, 8'h00, 8'h00);
        step();
        check("nmi_lost_after_reset", '0);
        drive(8'b1111_0000, 8'h00, 8'h00);
        step();

`ifdef JTKCPU_NMI_ARM_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(8'b1011_0000, 8'h00, 8'h00);
        step();
        drive(8'b1111_1000, 8'h00, 8'h00);
        step();
        check("nmi_disarmed", '0);
        drive(8'b1111_0000, 8'h00, 8'h00);
        s_wr = 1'b1;
        step();
        s_wr = 1'b0;
        drive(8'b1011_0000, 8'h00, 8'h00);
        step();
        drive(8'b1111_1000, 8'h00, 8'h00);
        step();
        check("nmi_armed", {10'b11_0100_0000, 8'h80, 8'h00, 16'h0000, 16'h0000});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/jtkcpu_intseq.md
Name: jtkcpu_intseq

Overview:
- Interrupt-entry and RTI sequencer for the KONAMI-1 core.
- Arbitrates NMI/FIRQ/IRQ, sets the CC E/F/I bits, and launches the stack push/pull unit with the correct mode strobes (psh_all, psh_cc, rti_cc, rti_other).
- Fetches the 16-bit vector and loads PC.
- Sits between the main control FSM (which offers instruction boundaries and RTI requests) and the push/pull unit and memory port.

Parameters:
- VEC_NMI, 16'hFFFC, NMI vector address (high byte first)
- VEC_IRQ, 16'hFFF8, IRQ vector address
- VEC_FIRQ, 16'hFFF6, FIRQ vector address

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  clock enable; all state advances only when cen=1
- nmi_n  in  1  NMI request, active-low, edge-triggered (falling)
- irq_n  in  1  IRQ request, active-low, level
- firq_n  in  1  FIRQ request, active-low, level
- cc  in  8  current condition-code register
- boundary  in  1  control FSM is at an instruction boundary; may start a sequence
- rti_req  in  1  RTI decoded; start the pull sequence
- pp_busy  in  1  push/pull unit busy
- mem_rdy  in  1  memory read data valid this cen cycle
- mem_din  in  8  memory read data
- psh_go  out  1  one-cen pulse: start push
- pul_go  out  1  one-cen pulse: start pull
- psh_all  out  1  push mode: all registers
- psh_cc  out  1  push mode: PC+CC only
- rti_cc  out  1  pull mode: CC only
- rti_other  out  1  pull mode: rest, selected by pulled E
- cc_set  out  8  CC bits to OR in this cycle (E/F/I)
- cc_clr  out  8  CC bits to clear this cycle
- vec_rd  out  1  vector read request
- vec_addr  out  16  vector byte address
- pc_ld  out  1  one-cen pulse: load PC from pc_din
- pc_din  out  16  vector value
- busy  out  1  sequence in progress; control FSM holds
- int_ack  out  1  one-cen pulse when PC is loaded from a vector

Behaviour:
- Reset: state IDLE; all outputs 0; NMI latch cleared; vec_addr=0.
- Requests:
  - nmi_n falling edge (sampled on cen) sets nmi_lat.
  - nmi_lat clears only on NMI entry; edges arriving during any sequence stay latched.
- Priority when boundary=1 and state IDLE:
  - nmi_lat > (!firq_n & !cc[CC_F]) > (!irq_n & !cc[CC_I]) > rti_req.
  - rti_req wins only if no interrupt qualifies.
- Entry path: IDLE→PSH→PWAIT→VHI→VLO→JMP→IDLE.
  - PSH, one cycle, for NMI/IRQ: cc_set=E; psh_go=1; psh_all=1.
  - PSH, one cycle, for FIRQ: cc_clr=E; psh_go=1; psh_cc=1.
  - E therefore lands in CC one cycle before the CC byte is stacked.
  - PWAIT: hold until pp_busy=0, with a minimum of 1 cycle after PSH because pp_busy rises the cycle after psh_go. Then apply masks: NMI/FIRQ set F|I; IRQ sets I.
  - VHI: vec_rd=1, vec_addr=VEC; capture mem_din as the high byte on mem_rdy.
  - VLO: vec_addr=VEC+1; capture the low byte on mem_rdy.
  - JMP: pc_ld=1, int_ack=1, pc_din={hi,lo}; busy drops next cycle.
- RTI path: IDLE→RCC→RCW→ROT→ROW→IDLE.
  - RCC: pul_go=1, rti_cc=1.
  - RCW: wait for pp_busy=0.
  - ROT: pul_go=1, rti_other=1. The pull unit decides full-frame vs PC-only from the pulled E bit.
  - ROW: wait for pp_busy=0.
- busy=1 in every state except IDLE. A request seen in the same cycle a sequence ends is taken only at the next boundary.
- Mode strobes are valid only while their go pulse is high; otherwise 0.
- cen=0 freezes all state and outputs. Pulses last exactly one cen-qualified cycle.
- Reset mid-sequence returns to IDLE immediately; a pending NMI is lost.

Optional Feature:
- Macro JTKCPU_NMI_ARM_EN.
- When defined:
  - adds input s_wr (system stack pointer written).
  - NMI edges are ignored and nmi_lat stays 0 until the first s_wr=1 after reset.
  - Once armed, stays armed until reset.
- When undefined: no s_wr port; NMI is accepted from reset.

Decomposition:
- Shared package/include:
  - CC bit indexes CC_E, CC_F, CC_I.
  - Vector address constants.
  - Sequencer state encoding localparams.
  - Interrupt source encoding (SRC_NMI, SRC_FIRQ, SRC_IRQ).
- One sub-module, jtkcpu_intsync: NMI falling-edge detector/latch, with the optional arming logic and the clear input.

Test Plan:
- IRQ entry: cc=8'h00, irq_n=0, boundary=1 → cc_set=8'h80 with psh_go and psh_all in the same cycle; after pp_busy falls, cc_set I; mem 16'hFFF8/9 = 12/34 → pc_ld with pc_din=16'h1234, int_ack=1.
- FIRQ over IRQ: both low, cc=8'h00 → FIRQ chosen, psh_cc=1, cc_clr E; vec_addr=16'hFFF6; F|I set.
- Masked: cc=8'h50, irq_n=firq_n=0, boundary=1 → busy stays 0; rti_req=1 same cycle → RTI path taken.
- NMI edge during a sequence: nmi_n pulse mid-IRQ entry → latched; at next boundary NMI enters using vec 16'hFFFC; latch clears.
- RTI: rti_req=1 → pul_go+rti_cc; after pp_busy low, pul_go+rti_other; busy clears after second pp_busy fall; no pc_ld.
- Reset mid-PWAIT and the macro case: rst → all outputs 0, state IDLE. With JTKCPU_NMI_ARM_EN, an NMI edge before s_wr is ignored and one after s_wr is taken.
